// File: rtl/mrr_fifo.sv
// Memory read register with a DEPTH-entry FIFO between the memory port and the
// ALU/regfile; each word carries its own width/extension mode to the read side.
module mrr_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [1:0]       mem_mode,
  output logic             mem_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    peak
);

  localparam int PW = $clog2(DEPTH);
  localparam int HW = WIDTH / 2;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [1:0]       mode_mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] peak_q, peak_d;

  logic full, empty, push, pop;
  logic [WIDTH-1:0] head_data;
  logic [1:0]       head_mode;
  logic [WIDTH-1:0] head_ext;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign push  = mem_valid & ~full;
  assign pop   = rd_ready & ~empty;

  // Pointers wrap naturally at PW bits because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    if (flush)                 peak_d = '0;
    else if (level_d > peak_q) peak_d = level_d;
    else                       peak_d = peak_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      peak_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      peak_q   <= peak_d;
    end
  end

  // Storage is not reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem_q[wr_ptr_q] <= mem_data;
      mode_mem_q[wr_ptr_q] <= mem_mode;
    end
  end

  assign head_data = data_mem_q[rd_ptr_q];
  assign head_mode = mode_mem_q[rd_ptr_q];

  always_comb begin
    case (head_mode)
      2'b01:   head_ext = {{(WIDTH-8){1'b0}}, head_data[7:0]};
      2'b10:   head_ext = {{(WIDTH-8){head_data[7]}}, head_data[7:0]};
      2'b11:   head_ext = {{(WIDTH-HW){head_data[HW-1]}}, head_data[HW-1:0]};
      default: head_ext = head_data;
    endcase
  end

  assign rd_data   = empty ? '0 : head_ext;
  assign rd_valid  = ~empty;
  assign mem_ready = ~full;
  assign level     = level_q;
  assign peak      = peak_q;

endmodule

// File: tb/tb_mrr_fifo.sv
// Self-checking bench for mrr_fifo (WIDTH=20, DEPTH=4) using a queue scoreboard
// of expected extended read words.
module tb_mrr_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        mem_valid;
  logic [19:0] mem_data;
  logic [1:0]  mem_mode;
  logic        mem_ready;
  logic        rd_valid;
  logic [19:0] rd_data;
  logic        rd_ready;
  logic [2:0]  level;
  logic [2:0]  peak;

  int checks   = 0;
  int failures = 0;

  logic [19:0] sb[$];
  int m_level = 0;
  int m_peak  = 0;

  mrr_fifo #(.WIDTH(20), .DEPTH(4), .LW(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .mem_valid(mem_valid), .mem_data(mem_data), .mem_mode(mem_mode),
    .mem_ready(mem_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .level(level), .peak(peak)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] ext(input logic [19:0] d, input logic [1:0] m);
    case (m)
      2'd1:    return d & 20'h000FF;
      2'd2:    return d[7] ? (d | 20'hFFF00) : (d & 20'h000FF);
      2'd3:    return d[9] ? (d | 20'hFFC00) : (d & 20'h003FF);
      default: return d;
    endcase
  endfunction

  // One clock edge; the model updates from the inputs held across the edge.
  task automatic clk_step();
    bit do_flush = flush;
    bit do_push  = mem_valid && (m_level < 4);
    bit do_pop   = rd_ready && (m_level > 0);
    logic [19:0] ev = ext(mem_data, mem_mode);
    @(posedge clk);
    #1;
    if (do_flush) begin
      sb.delete();
      m_level = 0;
      m_peak  = 0;
    end else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(ev);
      m_level = sb.size();
      if (m_level > m_peak) m_peak = m_level;
    end
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    mem_valid = 1'b0;
    mem_data  = '0;
    mem_mode  = 2'd0;
    rd_ready  = 1'b0;
  endtask

  task automatic drain(input string name);
    rd_ready  = 1'b1;
    mem_valid = 1'b0;
    for (int i = 0; i < 8 && m_level > 0; i++) begin
      checks++;
      if (rd_data !== sb[0]) begin
        failures++;
        $display("FAIL %s_drain[%0d] rd_data got=%h exp=%h", name, i, rd_data, sb[0]);
      end
      clk_step();
    end
    rd_ready = 1'b0;
    checks++;
    if (level !== 3'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_empty level=%0d rd_valid=%b exp 0/0", name, level, rd_valid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_ready, rd_valid, rd_data, level, peak} !== {1'b1, 1'b0, 20'h0, 3'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%h lvl=%0d pk=%0d exp 1/0/0/0/0",
               mem_ready, rd_valid, rd_data, level, peak);
    end
    #3 rst_n = 1'b1;
    sb.delete();
    m_level = 0;
    m_peak  = 0;
    clk_step();
  endtask

  task automatic test_single();
    mem_valid = 1'b1;
    mem_data  = 20'hAAAAA;
    mem_mode  = 2'd0;
    clk_step();
    mem_valid = 1'b0;
    checks++;
    if ({rd_valid, rd_data, level} !== {1'b1, 20'hAAAAA, 3'd1}) begin
      failures++;
      $display("FAIL single_push got vld=%b data=%h lvl=%0d exp 1/aaaaa/1", rd_valid, rd_data, level);
    end
    drain("single");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_data  = 20'($urandom);
      mem_mode  = 2'($urandom_range(0, 3));
      clk_step();
    end
    checks++;
    if (level !== 3'd4 || mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full level=%0d mem_ready=%b exp 4/0", level, mem_ready);
    end
    mem_data = 20'h12345;
    clk_step();
    mem_valid = 1'b0;
    checks++;
    if (level !== 3'd4 || sb.size() != 4) begin
      failures++;
      $display("FAIL fifth_ignored level=%0d exp 4", level);
    end
    checks++;
    if (peak !== 3'(m_peak)) begin
      failures++;
      $display("FAIL fill_peak got=%0d exp=%0d", peak, m_peak);
    end
    drain("fill");
  endtask

  task automatic test_modes();
    logic [19:0] din [4]  = '{20'h00080, 20'h00080, 20'h00080, 20'h00200};
    logic [1:0]  mdin [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [19:0] want [4] = '{20'h00080, 20'hFFF80, 20'h00080, 20'hFFE00};
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_data  = din[i];
      mem_mode  = mdin[i];
      clk_step();
    end
    mem_valid = 1'b0;
    rd_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data !== want[i]) begin
        failures++;
        $display("FAIL mode[%0d] rd_data got=%h exp=%h", i, rd_data, want[i]);
      end
      clk_step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1;
      mem_data  = 20'h10000 + 20'(i);
      mem_mode  = 2'd0;
      clk_step();
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_data = 20'h20000 + 20'(i * 3);
      mem_mode = 2'(i);
      checks++;
      if (rd_data !== sb[0]) begin
        failures++;
        $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rd_data, sb[0]);
      end
      clk_step();
      checks++;
      if (level !== 3'd2) begin
        failures++;
        $display("FAIL b2b_level[%0d] got=%0d exp=2", i, level);
      end
    end
    drain("b2b");
  endtask

  task automatic test_full_pop();
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_data  = 20'h30000 + 20'(i);
      mem_mode  = 2'd0;
      clk_step();
    end
    mem_data = 20'h3FFFF;
    rd_ready = 1'b1;
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_low got=%b exp=0", mem_ready);
    end
    clk_step();
    rd_ready  = 1'b0;
    mem_valid = 1'b0;
    checks++;
    if (level !== 3'd3 || mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_only level=%0d mem_ready=%b exp 3/1", level, mem_ready);
    end
    drain("fullpop");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1;
      mem_data  = 20'h40000 + 20'(i);
      mem_mode  = 2'd0;
      clk_step();
    end
    mem_data = 20'h4ABCD;
    flush    = 1'b1;
    clk_step();
    flush     = 1'b0;
    mem_valid = 1'b0;
    checks++;
    if ({level, peak, rd_valid, mem_ready, rd_data} !== {3'd0, 3'd0, 1'b0, 1'b1, 20'h0}) begin
      failures++;
      $display("FAIL flush_state lvl=%0d pk=%0d vld=%b rdy=%b data=%h exp 0/0/0/1/0",
               level, peak, rd_valid, mem_ready, rd_data);
    end
    mem_valid = 1'b1;
    mem_data  = 20'h05A5A;
    clk_step();
    mem_valid = 1'b0;
    checks++;
    if (rd_data !== 20'h05A5A || level !== 3'd1 || peak !== 3'd1) begin
      failures++;
      $display("FAIL flush_word_lost data=%h lvl=%0d pk=%0d exp 05a5a/1/1", rd_data, level, peak);
    end
    drain("flush");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1;
      mem_data  = 20'h50000 + 20'(i);
      mem_mode  = 2'd0;
      clk_step();
    end
    mem_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_valid, level, mem_ready, peak, rd_data} !== {1'b0, 3'd0, 1'b1, 3'd0, 20'h0}) begin
      failures++;
      $display("FAIL async_reset vld=%b lvl=%0d rdy=%b pk=%0d data=%h exp 0/0/1/0/0",
               rd_valid, level, mem_ready, peak, rd_data);
    end
    #2 rst_n = 1'b1;
    sb.delete();
    m_level = 0;
    m_peak  = 0;
    clk_step();
    checks++;
    if (level !== 3'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset level=%0d rd_valid=%b exp 0/0", level, rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_modes();
    test_back_to_back();
    test_full_pop();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
